// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter for the execute stage: SLL/SRL/SRA/ROR, shifting up to STEP bits per
// cycle under a start/ready/done handshake, with a kill that abandons an operation in flight.
module iter_shift_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SAW   = 5,
   parameter int unsigned STEP  = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             kill,
   input  logic [1:0]       mode,
   input  logic             var_amt,
   input  logic [SAW-1:0]   sa,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   localparam logic [SAW-1:0] StepAmt = SAW'(STEP);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [SAW-1:0]     rem_q, rem_d;
   logic [1:0]         mode_q, mode_d;
   logic [SAW-1:0]     step_k;
   logic [2*WIDTH-1:0] rot;
   logic [WIDTH-1:0]   shifted;

   // Only the low SAW bits of rs select an amount.
   logic unused_rs;
   assign unused_rs = ^rs[WIDTH-1:SAW];

   always_comb begin
      step_k  = (rem_q < StepAmt) ? rem_q : StepAmt;
      rot     = {data_q, data_q} >> step_k;
      shifted = data_q;
      unique case (mode_q)
         2'b00: shifted = data_q << step_k;
         2'b01: shifted = data_q >> step_k;
         // The MSB never changes across SRA steps, so it is always the captured sign bit.
         2'b10: shifted = $signed(data_q) >>> step_k;
         2'b11: shifted = rot[WIDTH-1:0];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      rem_d    = rem_q;
      mode_d   = mode_q;
      result_d = result_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               data_d  = rt;
               mode_d  = mode;
               rem_d   = var_amt ? rs[SAW-1:0] : sa;
               state_d = StShift;
            end
         end
         StShift: begin
            if (kill) begin
               state_d = StIdle;
            end else if (rem_q != '0) begin
               data_d = shifted;
               rem_d  = rem_q - step_k;
            end else begin
               result_d = data_q;
               state_d  = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= StIdle;
         data_q   <= '0;
         rem_q    <= '0;
         mode_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         rem_q    <= rem_d;
         mode_q   <= mode_d;
         result_q <= result_d;
      end
   end

   assign ready  = (state_q == StIdle);
   assign busy   = (state_q != StIdle);
   assign done   = (state_q == StDone);
   assign result = result_q;

endmodule
